// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop input synchronizer, 3-sample majority vote
// per bit, optional even/odd parity, one or two stop bits, parity/framing flags.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS);
  localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic        ODD  = 1'(PARITY_MODE == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 sync_meta, sync_line;
  logic [2:0]           state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 samp_a, samp_a_n, samp_b, samp_b_n;
  logic                 par_err, par_err_n, frm_err, frm_err_n;
  logic                 rx_dv, dv_n;
  logic [DATA_BITS-1:0] rx_byte, byte_n;
  logic                 parity_err, perr_n, frame_err, ferr_n;
  logic                 busy, busy_n;
  logic                 at_a, at_b, at_dec, at_end, vote;

  // Window position decodes and the majority of the three samples
  assign at_a   = (cnt == CW'(HALF - 1));
  assign at_b   = (cnt == CW'(HALF));
  assign at_dec = (cnt == CW'(HALF + 1));
  assign at_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign vote   = (samp_a & samp_b) | (samp_a & sync_line) | (samp_b & sync_line);

  // Next-state and output logic; the frame ends early at the last stop-bit decision
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shift_n   = shift;
    samp_a_n  = samp_a;
    samp_b_n  = samp_b;
    par_err_n = par_err;
    frm_err_n = frm_err;
    dv_n      = 1'b0;
    byte_n    = rx_byte;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;

    if (state != S_IDLE) begin
      cnt_n = at_end ? '0 : cnt + CW'(1);
      if (at_a) samp_a_n = sync_line;
      if (at_b) samp_b_n = sync_line;
    end

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (!sync_line) begin
          state_n   = S_START;
          par_err_n = 1'b0;
          frm_err_n = 1'b0;
        end
      end
      S_START: begin
        if (at_dec && vote) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (at_end) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (at_dec) shift_n[bit_idx] = vote;
        if (at_end) begin
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            bit_n   = '0;
            state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (at_dec && ((^shift ^ vote) != ODD)) par_err_n = 1'b1;
        if (at_end) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (at_dec) begin
          if (!vote) frm_err_n = 1'b1;
          if (bit_idx == BW'(STOP_BITS - 1)) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            bit_n   = '0;
            dv_n    = 1'b1;
            byte_n  = shift;
            perr_n  = par_err;
            ferr_n  = frm_err | ~vote;
          end
        end else if (at_end) begin
          bit_n = bit_idx + BW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_meta  <= 1'b1;
      sync_line  <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      rx_dv      <= 1'b0;
      rx_byte    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync_meta  <= i_RX_Serial;
      sync_line  <= sync_meta;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      samp_a     <= samp_a_n;
      samp_b     <= samp_b_n;
      par_err    <= par_err_n;
      frm_err    <= frm_err_n;
      rx_dv      <= dv_n;
      rx_byte    <= byte_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      busy       <= busy_n;
    end
  end

  assign o_RX_DV      = rx_dv;
  assign o_RX_Byte    = rx_byte;
  assign o_Parity_Err = parity_err;
  assign o_Frame_Err  = frame_err;
  assign o_Busy       = busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four receivers (8N1, 8E1, 8O1, 7N2) on one clock, a
// pin-level frame decoder as reference, per-cycle compare plus literal checks.
module tb_uart_rx_cfg;
  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  localparam int NL   = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] ser;
  logic [3:0] dv, pe, fe, busy;
  logic [7:0] b0, b1, b2;
  logic [6:0] b3;

  int total = 0;
  int bad   = 0;

  function automatic int db_of(input int l); return (l == 3) ? 7 : 8; endfunction
  function automatic int pm_of(input int l); return (l == 1) ? 1 : (l == 2) ? 2 : 0; endfunction
  function automatic int sb_of(input int l); return (l == 3) ? 2 : 1; endfunction

  function automatic logic [8:0] ob(input int l);
    case (l)
      0:       return {1'b0, b0};
      1:       return {1'b0, b1};
      2:       return {1'b0, b2};
      default: return {2'b0, b3};
    endcase
  endfunction

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(ser[0]), .o_RX_DV(dv[0]),
    .o_RX_Byte(b0), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Busy(busy[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(ser[1]), .o_RX_DV(dv[1]),
    .o_RX_Byte(b1), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Busy(busy[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(ser[2]), .o_RX_DV(dv[2]),
    .o_RX_Byte(b2), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Busy(busy[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(ser[3]), .o_RX_DV(dv[3]),
    .o_RX_Byte(b3), .o_Parity_Err(pe[3]), .o_Frame_Err(fe[3]), .o_Busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int l, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s lane%0d actual=%0h required=%0h", nm, l, a, e);
    end
  endtask

  // Reference: line = pin delayed 3 edges; frames decoded by sample-time arithmetic
  int         cyc;
  logic       d1[NL], d2[NL];
  bit         act[NL];
  int         st[NL], ones[NL];
  logic [8:0] word[NL], held[NL];
  logic       pbit[NL], ferr[NL];
  logic       e_dv[NL], e_pe[NL], e_fe[NL];

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      d1[l] = 1'b1; d2[l] = 1'b1; act[l] = 1'b0; ones[l] = 0; st[l] = 0;
      e_dv[l] = 1'b0; e_pe[l] = 1'b0; e_fe[l] = 1'b0; held[l] = '0;
      word[l] = '0; pbit[l] = 1'b0; ferr[l] = 1'b0;
    end
  endtask

  task automatic model_step(input int l);
    logic line, bv;
    int t, w, c, db, pm, nw;
    line  = d2[l];
    d2[l] = d1[l];
    d1[l] = ser[l];
    e_dv[l] = 1'b0; e_pe[l] = 1'b0; e_fe[l] = 1'b0;
    db = db_of(l);
    pm = pm_of(l);
    nw = 1 + db + ((pm != 0) ? 1 : 0) + sb_of(l);
    if (!act[l]) begin
      if (!line) begin
        act[l] = 1'b1; st[l] = cyc; ones[l] = 0;
        word[l] = '0; pbit[l] = 1'b0; ferr[l] = 1'b0;
      end
    end else begin
      t = cyc - st[l] - 1;
      w = t / CPB;
      c = t % CPB;
      if (c >= HALF - 1 && c <= HALF + 1 && line) ones[l]++;
      if (c == HALF + 1) begin
        bv = (ones[l] >= 2);
        ones[l] = 0;
        if (w == 0) begin
          if (bv) act[l] = 1'b0;
        end else if (w <= db) word[l][w-1] = bv;
        else if (pm != 0 && w == db + 1) pbit[l] = bv;
        else if (!bv) ferr[l] = 1'b1;
        if (w == nw - 1) begin
          act[l]  = 1'b0;
          e_dv[l] = 1'b1;
          e_pe[l] = (pm != 0) && (((^word[l]) ^ pbit[l]) != (pm == 2));
          e_fe[l] = ferr[l];
          held[l] = word[l];
        end
      end
    end
  endtask

  initial begin : model
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        cyc++;
        for (int l = 0; l < NL; l++) model_step(l);
      end
    end
  end

  // Per-cycle compare against the reference, plus bookkeeping for literal checks
  int         dv_cnt[NL], dv_cyc[NL], busy_cnt[NL], zfe[NL];
  logic [8:0] last_b[NL];
  logic       last_pe[NL], last_fe[NL], busy_at_dv[NL];

  initial begin : cmp
    for (int l = 0; l < NL; l++) begin
      dv_cnt[l] = 0; dv_cyc[l] = 0; busy_cnt[l] = 0; zfe[l] = 0;
      last_b[l] = '0; last_pe[l] = 1'b0; last_fe[l] = 1'b0; busy_at_dv[l] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (!rst_n) begin
          chk("rst_dv", l, 32'(dv[l]), 0);
          chk("rst_byte", l, 32'(ob(l)), 0);
          chk("rst_flags", l, 32'({pe[l], fe[l], busy[l]}), 0);
        end else begin
          chk("dv", l, 32'(dv[l]), 32'(e_dv[l]));
          chk("busy", l, 32'(busy[l]), 32'(act[l]));
          chk("byte", l, 32'(ob(l)), 32'(held[l]));
          chk("perr", l, 32'(pe[l]), 32'(e_pe[l]));
          chk("ferr", l, 32'(fe[l]), 32'(e_fe[l]));
          if (dv[l]) begin
            dv_cnt[l]++;
            dv_cyc[l] = cyc;
            last_b[l] = ob(l);
            last_pe[l] = pe[l];
            last_fe[l] = fe[l];
            busy_at_dv[l] = busy[l];
            if (ob(l) == 9'd0 && fe[l]) zfe[l]++;
          end
          if (busy[l]) busy_cnt[l]++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic hold(input int l, input logic v, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 ser[l] = v;
    end
  endtask

  // One frame on lane l; pf<0 gives correct parity, else forces the parity bit.
  // Optional spike inverts pin offsets soff..soff+slen-1 of window sw.
  task automatic send(input int l, input logic [8:0] d, input int pf, input logic stv,
                      input int sw, input int soff, input int slen, output int fc);
    logic b[16];
    logic par, v;
    int db, pm, nw, idx;
    db = db_of(l);
    pm = pm_of(l);
    par = 1'b0;
    b[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      b[1+i] = d[i];
      par ^= d[i];
    end
    idx = 1 + db;
    if (pm != 0) begin
      b[idx] = (pf < 0) ? ((pm == 1) ? par : ~par) : pf[0];
      idx++;
    end
    for (int s = 0; s < sb_of(l); s++) b[idx+s] = stv;
    nw = idx + sb_of(l);
    fc = 0;
    for (int w = 0; w < nw; w++) begin
      for (int c = 0; c < CPB; c++) begin
        v = b[w];
        if (w == sw && c >= soff && c < soff + slen) v = ~v;
        @(posedge clk);
        #1;
        if (w == 0 && c == 0) fc = cyc;
        ser[l] = v;
      end
    end
  endtask

  initial begin : stim
    int fc, fc2, n0, bc0, z0, lat, l, pf, sw;
    logic [8:0] d;
    logic stv;
    ser   = 4'hF;
    rst_n = 1'b0;
    idle(5);
    #2 rst_n = 1'b1;
    idle(10);

    // 8N1 0xA5: value, flags, latency from line fall, busy low on DV
    n0 = dv_cnt[0];
    send(0, 9'h0A5, -1, 1'b1, -1, 0, 0, fc);
    idle(10);
    chk("a5_count", 0, 32'(dv_cnt[0] - n0), 1);
    chk("a5_byte", 0, 32'(last_b[0]), 32'h0A5);
    chk("a5_flags", 0, 32'({last_pe[0], last_fe[0]}), 0);
    lat = dv_cyc[0] - fc;
    chk("a5_latency_in_154_156", 0, 32'(lat >= 154 && lat <= 156), 1);
    chk("a5_busy_at_dv", 0, 32'(busy_at_dv[0]), 0);

    // Even and odd parity on 0x07 with both parity-bit values
    send(1, 9'h007, 1, 1'b1, -1, 0, 0, fc); idle(5);
    chk("even_p1_perr", 1, 32'(last_pe[1]), 0);
    send(1, 9'h007, 0, 1'b1, -1, 0, 0, fc); idle(5);
    chk("even_p0_perr", 1, 32'(last_pe[1]), 1);
    chk("even_p0_byte", 1, 32'(last_b[1]), 32'h07);
    send(2, 9'h007, 1, 1'b1, -1, 0, 0, fc); idle(5);
    chk("odd_p1_perr", 2, 32'(last_pe[2]), 1);
    send(2, 9'h007, 0, 1'b1, -1, 0, 0, fc); idle(5);
    chk("odd_p0_perr", 2, 32'(last_pe[2]), 0);
    chk("odd_p0_byte", 2, 32'(last_b[2]), 32'h07);

    // 4-cycle low glitch is rejected, then a clean 0x3C frame
    bc0 = busy_cnt[0];
    n0  = dv_cnt[0];
    hold(0, 1'b0, 4);
    hold(0, 1'b1, 30);
    chk("glitch_busy_cycles", 0, 32'(busy_cnt[0] - bc0), 9);
    chk("glitch_no_dv", 0, 32'(dv_cnt[0] - n0), 0);
    send(0, 9'h03C, -1, 1'b1, -1, 0, 0, fc); idle(5);
    chk("after_glitch_byte", 0, 32'(last_b[0]), 32'h3C);

    // Stop bit low, then a break of three frame times
    send(0, 9'h055, -1, 1'b0, -1, 0, 0, fc);
    chk("stop0_byte", 0, 32'(last_b[0]), 32'h55);
    chk("stop0_ferr", 0, 32'(last_fe[0]), 1);
    hold(0, 1'b1, 40);
    z0 = zfe[0];
    hold(0, 1'b0, 480);
    hold(0, 1'b1, 400);
    chk("break_zero_ferr_frames_ge3", 0, 32'((zfe[0] - z0) >= 3), 1);

    // Spikes on data bit 3 of 0xF0 (pin offsets 8 and 8..9 = counts 7 and 7..8)
    send(0, 9'h0F0, -1, 1'b1, 4, 8, 1, fc); idle(5);
    chk("spike1_byte", 0, 32'(last_b[0]), 32'hF0);
    send(0, 9'h0F0, -1, 1'b1, 4, 8, 2, fc); idle(5);
    chk("spike2_byte", 0, 32'(last_b[0]), 32'hF8);

    // 7N2 back-to-back frames
    n0 = dv_cnt[3];
    send(3, 9'h041, -1, 1'b1, -1, 0, 0, fc);
    chk("b2b_first", 3, 32'(last_b[3]), 32'h41);
    send(3, 9'h07F, -1, 1'b1, -1, 0, 0, fc);
    idle(5);
    chk("b2b_second", 3, 32'(last_b[3]), 32'h7F);
    chk("b2b_count", 3, 32'(dv_cnt[3] - n0), 2);

    // Reset in the middle of a frame, then a clean 0x12
    n0 = dv_cnt[3];
    fork
      send(3, 9'h02A, -1, 1'b1, -1, 0, 0, fc2);
      begin
        idle(70);
        #2 rst_n = 1'b0;
        idle(3);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_dv", 3, 32'(dv_cnt[3] - n0), 0);
        chk("post_rst_byte", 3, 32'(ob(3)), 0);
        chk("post_rst_busy", 3, 32'(busy[3]), 0);
      end
    join
    hold(3, 1'b1, 300);
    send(3, 9'h012, -1, 1'b1, -1, 0, 0, fc); idle(5);
    chk("after_rst_byte", 3, 32'(last_b[3]), 32'h12);

    // Randomized frames across lanes: data, parity, stop, spikes and gaps
    for (int i = 0; i < 48; i++) begin
      l   = int'($urandom_range(0, 3));
      d   = 9'($urandom_range(0, 511));
      pf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      stv = ($urandom_range(0, 6) != 0);
      sw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1;
      send(l, d, pf, stv, sw, int'($urandom_range(0, 15)), int'($urandom_range(1, 2)), fc);
      hold(l, 1'b1, int'($urandom_range(stv ? 0 : 1, 10)));
    end
    for (int k = 0; k < NL; k++) hold(k, 1'b1, 1);
    idle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised UART receiver.
- Data width, parity mode and stop-bit count are configurable; each bit is decided by a 3-sample majority vote.
- Reports parity and framing errors alongside each received word.
- Sits between the external RX pin and the byte-consumer logic, and replaces the fixed 8N1 receiver in new designs.

Parameters:
- CLKS_PER_BIT, 217, clocks per bit = f(i_Clock)/baud; legal range >= 8.
- DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- i_Clock  in  1  single system clock, rising edge.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_RX_Serial  in  1  asynchronous serial line; idles high.
- o_RX_DV  out  1  one-cycle pulse: word, and both error flags, valid.
- o_RX_Byte  out  DATA_BITS  last received word; held until the next o_RX_DV.
- o_Parity_Err  out  1  pulses with o_RX_DV when the parity check fails; always 0 when PARITY_MODE = 0.
- o_Frame_Err  out  1  pulses with o_RX_DV when any stop bit is decided 0.
- o_Busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: the only reset is i_Rst_L, asynchronous and active-low.
  - All outputs reset to 0; o_RX_Byte resets to all zeros.
  - FSM goes to IDLE and counters go to 0.
  - Synchronizer flops reset to 1, so no false start is seen on release.
- Input path: a 2-flop synchronizer feeds all logic. "Line" below means the synchronized value.
- Timing terms:
  - HALF = (CLKS_PER_BIT-1)/2, integer division.
  - Clock counter width = $clog2(CLKS_PER_BIT).
  - A bit window is CLKS_PER_BIT cycles, counted 0..CLKS_PER_BIT-1.
- Sampling:
  - The line is sampled at window counts HALF-1, HALF and HALF+1.
  - The bit value is the majority of the 3 samples, decided at count HALF+1.
  - At count CLKS_PER_BIT-1 the counter wraps to 0 and the next window begins.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: counter and bit index held at 0. Line = 0 → START with counter = 0 on the next cycle; that cycle is window count 0.
  - START: start-bit decision = 1 → IDLE, no o_RX_DV, no error flag (glitch reject). Decision = 0 → finish the window, then DATA.
  - DATA: each decision is written to shift position bit_index (LSB first). After window DATA_BITS-1 completes → PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: the decided bit is XORed with the data bits. Even mode: total XOR must be 0. Odd mode: total XOR must be 1. A mismatch latches an internal parity error.
  - STOP: the internal frame error is ORed with each stop decision == 0.
    - Non-final stop windows run to completion.
    - At the decision point (count HALF+1) of the final stop window, the FSM goes directly to IDLE without waiting out the window.
    - On that same edge, o_RX_Byte and the error flags load and o_RX_DV rises. All three are high for exactly the following cycle.
- Consequences of the early return to IDLE:
  - A start edge arriving within half a bit of the stop centre is captured, so back-to-back frames are received.
  - A frame error does not suppress data; the word is still delivered.
- Break condition: a line held low yields data = 0, o_Frame_Err = 1, then repeated frames while the line stays low. No special state is used.
- Reset mid-frame: the frame is abandoned and no o_RX_DV is produced. After release, the first low line is treated as a new start bit.
- Internal error latches clear on entry to START.
- No FIFO: the consumer must take o_RX_Byte before the next o_RX_DV. An unread word is overwritten silently.

Test Plan:
- CLKS_PER_BIT = 16, 8N1, line sends 0xA5 → o_RX_DV single pulse; o_RX_Byte = 0xA5; both error flags 0. DV rises 9*16+9+2 = 155 cycles (±1) after the line falls. o_Busy falls with the DV edge.
- PARITY_MODE = 1, send 0x07 with parity bit 1 → DV, o_Parity_Err = 0. Same data with parity bit 0 → DV, o_RX_Byte = 0x07, o_Parity_Err = 1. Repeat with PARITY_MODE = 2; expected results invert.
- Line low for 4 cycles then high → FSM returns to IDLE after the start decision; no DV; o_Busy high for about 9 cycles then 0. A following valid 0x3C frame is received correctly.
- Stop bit driven 0 on 0x55 → DV, o_RX_Byte = 0x55, o_Frame_Err = 1. Line held low for 3 frame times → repeated DV with 0x00 and o_Frame_Err = 1.
- 1-cycle inverted spike at count 7 of data bit 3 of 0xF0 → majority rejects it; o_RX_Byte = 0xF0. A 2-cycle spike at counts 7-8 → bit flipped; o_RX_Byte = 0xF8.
- DATA_BITS = 7, STOP_BITS = 2: frames 0x41 then 0x7F sent back-to-back with no idle → two DV pulses, values 0x41 and 0x7F. i_Rst_L pulsed low mid-second-frame → no DV, all outputs 0; the next frame 0x12 is received correctly.
